// File: rtl/pipelined_csel_adder_if.sv
// rtl/pipelined_csel_adder_if.sv - operand/result handshake bundle for pipelined_csel_adder
//
// Ports carried:
//   in_valid/in_ready   operand handshake (producer -> adder)
//   a, b, c_in, sub     operands, carry-in, subtract select
//   out_valid/out_ready result handshake (adder -> consumer)
//   s, c_out, v         sum/difference, carry out of MSB, signed overflow
// Modports: master = operand producer / result consumer, slave = the adder.
interface pipelined_csel_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             c_out;
    logic             v;

    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, s, c_out, v
    );

    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, s, c_out, v
    );
endinterface

// File: rtl/pipelined_csel_adder.sv
// rtl/pipelined_csel_adder.sv - pipelined carry-select adder/subtractor with valid/ready handshake
//
// Parameters:
//   WIDTH  operand/result width, multiple of BLOCK
//   BLOCK  carry-select slice width
//   BPS    slices resolved per pipeline stage; WIDTH/BLOCK must be a multiple of BPS
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      pipelined_csel_adder_if.slave (operands in, result out)
// Latency is (WIDTH/BLOCK)/BPS cycles; one op per cycle while the consumer accepts.
module pipelined_csel_adder #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4,
    parameter int BPS   = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    pipelined_csel_adder_if.slave  bus
);
    localparam int NBLK = WIDTH / BLOCK;
    localparam int LAT  = NBLK / BPS;
    localparam int MSB  = WIDTH - 1;

    // Stage i holds the op after slices 0 .. i*BPS-1 have been resolved.
    // Operand bits are kept whole; later stages only read their unresolved part
    // plus the MSBs needed for overflow at the output.
    logic             stg_valid [1:LAT];
    logic [WIDTH-1:0] stg_a     [1:LAT];
    logic [WIDTH-1:0] stg_b     [1:LAT];
    logic [WIDTH-1:0] stg_sum   [1:LAT];
    logic             stg_cy    [1:LAT];

    logic             nxt_valid [1:LAT];
    logic [WIDTH-1:0] nxt_a     [1:LAT];
    logic [WIDTH-1:0] nxt_b     [1:LAT];
    logic [WIDTH-1:0] nxt_sum   [1:LAT];
    logic             nxt_cy    [1:LAT];

    logic advance;

    // Single global enable: the whole pipe moves unless a result is parked at the output.
    assign advance      = !stg_valid[LAT] || bus.out_ready;
    assign bus.in_ready = advance;

    always_comb begin : resolve
        logic [WIDTH-1:0] cur_a;
        logic [WIDTH-1:0] cur_b;
        logic [WIDTH-1:0] cur_sum;
        logic             cur_cy;
        logic             cur_vld;
        logic [BLOCK:0]   sum0;
        logic [BLOCK:0]   sum1;
        int               k;

        cur_a   = '0;
        cur_b   = '0;
        cur_sum = '0;
        cur_cy  = 1'b0;
        cur_vld = 1'b0;
        sum0    = '0;
        sum1    = '0;
        k       = 0;

        for (int i = 1; i <= LAT; i++) begin
            if (i == 1) begin
                // Subtraction folds into the first stage as a bitwise invert of B;
                // the caller supplies the +1 through c_in.
                cur_a   = bus.a;
                cur_b   = bus.sub ? ~bus.b : bus.b;
                cur_sum = '0;
                cur_cy  = bus.c_in;
                cur_vld = bus.in_valid;
            end else begin
                cur_a   = stg_a[i-1];
                cur_b   = stg_b[i-1];
                cur_sum = stg_sum[i-1];
                cur_cy  = stg_cy[i-1];
                cur_vld = stg_valid[i-1];
            end

            for (int j = 0; j < BPS; j++) begin
                k    = (i - 1) * BPS + j;
                // Both candidate sums are formed independently of the incoming carry,
                // which then only drives the select.
                sum0 = {1'b0, cur_a[k*BLOCK +: BLOCK]} + {1'b0, cur_b[k*BLOCK +: BLOCK]};
                sum1 = {1'b0, cur_a[k*BLOCK +: BLOCK]} + {1'b0, cur_b[k*BLOCK +: BLOCK]}
                       + (BLOCK+1)'(1);
                {cur_cy, cur_sum[k*BLOCK +: BLOCK]} = cur_cy ? sum1 : sum0;
            end

            nxt_valid[i] = cur_vld;
            nxt_a[i]     = cur_a;
            nxt_b[i]     = cur_b;
            nxt_sum[i]   = cur_sum;
            nxt_cy[i]    = cur_cy;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 1; i <= LAT; i++) begin
                stg_valid[i] <= 1'b0;
                stg_a[i]     <= '0;
                stg_b[i]     <= '0;
                stg_sum[i]   <= '0;
                stg_cy[i]    <= 1'b0;
            end
        end else if (advance) begin
            for (int i = 1; i <= LAT; i++) begin
                stg_valid[i] <= nxt_valid[i];
                stg_a[i]     <= nxt_a[i];
                stg_b[i]     <= nxt_b[i];
                stg_sum[i]   <= nxt_sum[i];
                stg_cy[i]    <= nxt_cy[i];
            end
        end
    end

    assign bus.out_valid = stg_valid[LAT];
    assign bus.s         = stg_sum[LAT];
    assign bus.c_out     = stg_cy[LAT];
    // Derived from last-stage registers only, so it is cleared by reset and holds under stall.
    assign bus.v         = (stg_a[LAT][MSB] == stg_b[LAT][MSB]) &&
                           (stg_sum[LAT][MSB] != stg_a[LAT][MSB]);
endmodule
